ct_spsram_req_ctrl: RTL and testbench



---
 rtl/ct_spsram_req_ctrl_pkg.sv | 35 +++
 rtl/ct_spsram_req_ctrl_if.sv | 39 +++
 rtl/ct_spsram_req_ctrl_rsp_fifo.sv | 75 +++++++
 rtl/ct_spsram_req_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_ct_spsram_req_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ct_spsram_req_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ct_spsram_ctrl_pkg
// Purpose  : Shared constants, request record, init-sweep state encoding and
//            a small sizing helper for the SPSRAM requester controller.
// Contents : CT_SPSRAM_AW / CT_SPSRAM_DW default geometry (16384 x 128),
//            ct_spsram_req_t, ct_spsram_state_e, ct_spsram_cnt_w().
// Revision : 1.0 - initial release
// ============================================================================
package ct_spsram_ctrl_pkg;

  localparam int CT_SPSRAM_AW = 14;
  localparam int CT_SPSRAM_DW = 128;

  // One client request at the default macro geometry.
  typedef struct packed {
    logic                        wr;
    logic [CT_SPSRAM_AW-1:0]     addr;
    logic [CT_SPSRAM_DW-1:0]     wdata;
    logic [CT_SPSRAM_DW/8-1:0]   wstrb;
  } ct_spsram_req_t;

  // Post-reset zero-fill sweep, then normal traffic.
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ct_spsram_state_e;

  // Width of a counter that must hold the values 0..depth inclusive.
  function automatic int ct_spsram_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : ct_spsram_ctrl_pkg
`default_nettype wire

// File: rtl/ct_spsram_req_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ct_spsram_req_ctrl_if
// Purpose  : Client-side request/response bundle of the SPSRAM controller.
// Signals  : req_vld/req_rdy/req_wr/req_addr/req_wdata/req_wstrb (request),
//            rsp_vld/rsp_rdy/rsp_rdata (read response).
// Modports : master - the cache/buffer client
//            slave  - the controller
// Revision : 1.0 - initial release
// ============================================================================
interface ct_spsram_req_ctrl_if
  import ct_spsram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = CT_SPSRAM_AW,
  parameter int DATA_WIDTH = CT_SPSRAM_DW
);

  logic                    req_vld;
  logic                    req_rdy;
  logic                    req_wr;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [DATA_WIDTH/8-1:0] req_wstrb;
  logic                    rsp_vld;
  logic                    rsp_rdy;
  logic [DATA_WIDTH-1:0]   rsp_rdata;

  modport master (
    output req_vld, req_wr, req_addr, req_wdata, req_wstrb, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_rdata
  );

  modport slave (
    input  req_vld, req_wr, req_addr, req_wdata, req_wstrb, rsp_rdy,
    output req_rdy, rsp_vld, rsp_rdata
  );

endinterface : ct_spsram_req_ctrl_if
`default_nettype wire

// File: rtl/ct_spsram_req_ctrl_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ct_spsram_rsp_fifo
// Purpose  : Small synchronous FIFO holding read data until the consumer
//            takes it. Push and pop in the same cycle is legal at any
//            occupancy; the head entry is presented combinationally.
// Ports    : clk, rst_n (async, active-low)
//            i_push/i_wdata, i_pop -> o_rdata (head), o_full, o_empty,
//            o_count (occupancy 0..DEPTH)
// Revision : 1.0 - initial release
// ============================================================================
module ct_spsram_rsp_fifo
  import ct_spsram_ctrl_pkg::*;
#(
  parameter int WIDTH = CT_SPSRAM_DW,
  parameter int DEPTH = 4
) (
  input  wire logic                               clk,
  input  wire logic                               rst_n,
  input  wire logic                               i_push,
  input  wire logic [WIDTH-1:0]                   i_wdata,
  input  wire logic                               i_pop,
  output logic      [WIDTH-1:0]                   o_rdata,
  output logic                                    o_full,
  output logic                                    o_empty,
  output logic      [ct_spsram_cnt_w(DEPTH)-1:0]  o_count
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = ct_spsram_cnt_w(DEPTH);
  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == c_DEPTH);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  // A push into a full FIFO is only taken when a pop frees the head slot.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Storage is cleared so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : ct_spsram_rsp_fifo
`default_nettype wire

// File: rtl/ct_spsram_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ct_spsram_req_ctrl
// Purpose  : Requester-side controller for the ct_f_spsram_16384x128 macro.
//            Registers every macro pin, tracks the one-cycle macro read
//            latency with a tag pipeline and returns read data in order
//            through a credit-protected response FIFO.
// Ports    : forever_cpuclk, cpurst_b (async, active-low)
//            bus       - client request/response (slave modport)
//            init_done - client traffic permitted
//            sram_a/sram_cen/sram_gwen/sram_wen/sram_d -> macro, sram_q <- macro
// Options  : CT_SPSRAM_INIT_EN - zero-fill the whole array after reset
//            before accepting client traffic. Undefined: init_done is 1.
// Revision : 1.0 - initial release
// ============================================================================
module ct_spsram_req_ctrl
  import ct_spsram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = CT_SPSRAM_AW,
  parameter int DATA_WIDTH = CT_SPSRAM_DW,
  parameter int RSP_DEPTH  = 4
) (
  input  wire logic                  forever_cpuclk,
  input  wire logic                  cpurst_b,
  ct_spsram_req_ctrl_if.slave        bus,
  output logic                       init_done,
  output logic [ADDR_WIDTH-1:0]      sram_a,
  output logic                       sram_cen,
  output logic                       sram_gwen,
  output logic [DATA_WIDTH-1:0]      sram_wen,
  output logic [DATA_WIDTH-1:0]      sram_d,
  input  wire logic [DATA_WIDTH-1:0] sram_q
);

  localparam int c_STRB_W = DATA_WIDTH / 8;
  localparam int c_CNT_W  = ct_spsram_cnt_w(RSP_DEPTH);
  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(RSP_DEPTH);

  logic                  w_req_rdy;
  logic                  w_accept;
  logic                  w_rd_accept;
  logic                  w_pop;
  logic                  w_push;
  logic [DATA_WIDTH-1:0] w_wr_wen;
  logic                  w_init_active;
  logic [ADDR_WIDTH-1:0] w_init_addr;
  logic [c_CNT_W-1:0]    r_outstanding;
  logic [1:0]            r_rd_tag;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [c_CNT_W-1:0]    w_fifo_count;
  logic [DATA_WIDTH-1:0] w_fifo_rdata;

  // --------------------------------------------------------------------------
  // Optional zero-fill sweep
  // --------------------------------------------------------------------------
`ifdef CT_SPSRAM_INIT_EN
  ct_spsram_state_e      r_state;
  ct_spsram_state_e      w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_init_addr;
  logic [ADDR_WIDTH-1:0] w_init_addr_nxt;
  logic                  r_init_done;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_state     <= ST_INIT;
      r_init_addr <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_init_addr <= w_init_addr_nxt;
      // Lags the state by one cycle so the last sweep write has left the
      // pins before the first client request can be loaded.
      r_init_done <= (r_state == ST_RUN);
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_init_addr_nxt = r_init_addr;
    case (r_state)
      ST_INIT: begin
        w_init_addr_nxt = r_init_addr + ADDR_WIDTH'(1);
        if (r_init_addr == '1) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  assign w_init_active = (r_state == ST_INIT);
  assign w_init_addr   = r_init_addr;
  assign init_done     = r_init_done;
`else
  assign w_init_active = 1'b0;
  assign w_init_addr   = '0;
  assign init_done     = 1'b1;
`endif

  // --------------------------------------------------------------------------
  // Request handshake
  // --------------------------------------------------------------------------
  // Credit-based ready: never looks at the request fields.
  assign w_req_rdy   = init_done & (r_outstanding < c_DEPTH);
  assign bus.req_rdy = w_req_rdy;
  assign w_accept    = bus.req_vld & w_req_rdy;
  assign w_rd_accept = w_accept & ~bus.req_wr;
  assign w_pop       = bus.rsp_vld & bus.rsp_rdy;

  // Byte strobes expanded to the macro's bitwise active-low write enables.
  for (genvar g = 0; g < c_STRB_W; g++) begin : g_wen
    assign w_wr_wen[g*8 +: 8] = {8{~bus.req_wstrb[g]}};
  end

  // --------------------------------------------------------------------------
  // Macro pin register stage
  // --------------------------------------------------------------------------
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      sram_cen  <= 1'b1;
      sram_gwen <= 1'b1;
      sram_wen  <= '1;
      sram_a    <= '0;
      sram_d    <= '0;
    end else if (w_init_active) begin
      sram_cen  <= 1'b0;
      sram_gwen <= 1'b0;
      sram_wen  <= '0;
      sram_a    <= w_init_addr;
      sram_d    <= '0;
    end else if (w_accept) begin
      sram_cen  <= 1'b0;
      sram_gwen <= ~bus.req_wr;
      sram_a    <= bus.req_addr;
      if (bus.req_wr) begin
        sram_wen <= w_wr_wen;
        sram_d   <= bus.req_wdata;
      end else begin
        sram_wen <= '1;
      end
    end else begin
      sram_cen  <= 1'b1;
      sram_gwen <= 1'b1;
      sram_wen  <= '1;
    end
  end

  // --------------------------------------------------------------------------
  // Read tracking: tag[0] = pins carry a read, tag[1] = Q is valid now.
  // --------------------------------------------------------------------------
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_rd_tag <= '0;
    end else begin
      r_rd_tag <= {r_rd_tag[0], w_rd_accept};
    end
  end

  assign w_push = r_rd_tag[1];

  // Reads in flight plus reads waiting in the FIFO.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_outstanding <= '0;
    end else begin
      case ({w_rd_accept, w_pop})
        2'b10:   r_outstanding <= r_outstanding + c_CNT_W'(1);
        2'b01:   r_outstanding <= r_outstanding - c_CNT_W'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  ct_spsram_rsp_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk     (forever_cpuclk),
    .rst_n   (cpurst_b),
    .i_push  (w_push),
    .i_wdata (sram_q),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign bus.rsp_vld   = ~w_fifo_empty;
  assign bus.rsp_rdata = w_fifo_rdata;

  // The credit scheme must make overflow impossible.
  a_no_overflow : assert property (@(posedge forever_cpuclk) disable iff (!cpurst_b)
    !(w_push && w_fifo_full && !w_pop));

  a_credit_covers_fifo : assert property (@(posedge forever_cpuclk) disable iff (!cpurst_b)
    w_fifo_count <= r_outstanding);

endmodule : ct_spsram_req_ctrl
`default_nettype wire

// File: tb/tb_ct_spsram_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ct_spsram_req_ctrl
// Purpose  : Self-checking bench for ct_spsram_req_ctrl with a behavioural
//            macro, a reference memory and an in-order expected-data queue.
// Options  : CT_SPSRAM_INIT_EN - also exercises the zero-fill sweep.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ct_spsram_req_ctrl;
  import ct_spsram_ctrl_pkg::*;

  localparam int AW    = CT_SPSRAM_AW;
  localparam int DW    = CT_SPSRAM_DW;
  localparam int SW    = DW / 8;
  localparam int DEPTH = 4;

  logic          clk   = 1'b0;
  logic          rst_b = 1'b0;
  logic          init_done;
  logic [AW-1:0] sram_a;
  logic          sram_cen;
  logic          sram_gwen;
  logic [DW-1:0] sram_wen;
  logic [DW-1:0] sram_d;
  logic [DW-1:0] sram_q = '0;

  always #5 clk = ~clk;

  ct_spsram_req_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ct_spsram_req_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RSP_DEPTH  (DEPTH)
  ) u_dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_b),
    .bus            (bus.slave),
    .init_done      (init_done),
    .sram_a         (sram_a),
    .sram_cen       (sram_cen),
    .sram_gwen      (sram_gwen),
    .sram_wen       (sram_wen),
    .sram_d         (sram_d),
    .sram_q         (sram_q)
  );

  // Behavioural macro: one access per edge, Q valid the cycle after a read.
  logic [DW-1:0] mac [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1 << AW); i++) mac[i] = {SW{8'h5A}} ^ DW'(i);
  end
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen) mac[sram_a] <= (mac[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            sram_q      <= mac[sram_a];
    end
  end

  // ------------------------------------------------------------------ checks
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  // --------------------------------------------------------- reference model
  // Memory contents as the client sees them, updated in acceptance order.
  logic [DW-1:0] ref_mem [int];
  logic [DW-1:0] exp_q [$];

  function automatic logic [DW-1:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  bit            chk_en = 1'b0;
  bit            pin_ok = 1'b0;
  logic          exp_cen = 1'b1, exp_gwen = 1'b1;
  logic [DW-1:0] exp_wen = '1, exp_d = '0;
  logic [AW-1:0] exp_a = '0;
  int            acc_cnt = 0, rsp_cnt = 0, cyc = 0;

  always @(negedge clk) begin
    logic [DW-1:0] cur;
    cyc++;
    if (chk_en) begin
      if (pin_ok) begin
        check("pin_cen",  DW'(sram_cen),  DW'(exp_cen));
        check("pin_gwen", DW'(sram_gwen), DW'(exp_gwen));
        check("pin_wen",  sram_wen,       exp_wen);
        check("pin_a",    DW'(sram_a),    DW'(exp_a));
        check("pin_d",    sram_d,         exp_d);
      end
      if (bus.rsp_vld && bus.rsp_rdy) begin
        rsp_cnt++;
        if (exp_q.size() == 0) check("rsp_spurious", DW'(bus.rsp_vld), DW'(0));
        else                   check("rsp_data", bus.rsp_rdata, exp_q.pop_front());
      end
      if (bus.req_vld && bus.req_rdy) begin
        acc_cnt++;
        exp_cen  = 1'b0;
        exp_gwen = ~bus.req_wr;
        exp_a    = bus.req_addr;
        if (bus.req_wr) begin
          cur = ref_rd(int'(bus.req_addr));
          for (int b = 0; b < SW; b++) begin
            exp_wen[b*8 +: 8] = bus.req_wstrb[b] ? 8'h00 : 8'hFF;
            if (bus.req_wstrb[b]) cur[b*8 +: 8] = bus.req_wdata[b*8 +: 8];
          end
          ref_mem[int'(bus.req_addr)] = cur;
          exp_d = bus.req_wdata;
        end else begin
          exp_wen = '1;
          exp_q.push_back(ref_rd(int'(bus.req_addr)));
        end
      end else begin
        exp_cen  = 1'b1;
        exp_gwen = 1'b1;
        exp_wen  = '1;
      end
    end
    pin_ok = chk_en;
  end

  // ---------------------------------------------------------------- stimulus
  bit rnd_rdy = 1'b0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic ct_spsram_req_t mk_req(input logic wr, input logic [AW-1:0] a,
                                            input logic [DW-1:0] d, input logic [SW-1:0] s);
    ct_spsram_req_t r;
    r.wr = wr; r.addr = a; r.wdata = d; r.wstrb = s;
    return r;
  endfunction

  // Present one request and hold it until accepted (bounded).
  task automatic send(input ct_spsram_req_t r);
    logic acc;
    bus.req_vld   = 1'b1;
    bus.req_wr    = r.wr;
    bus.req_addr  = r.addr;
    bus.req_wdata = r.wdata;
    bus.req_wstrb = r.wstrb;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      acc = bus.req_rdy;
      @(posedge clk);
      #1;
      if (acc) break;
      if (rnd_rdy && !bus.rsp_rdy) bus.rsp_rdy = 1'($urandom_range(0, 1));
      if (n == 199) check("req_timeout", DW'(bus.req_rdy), DW'(1));
    end
    bus.req_vld = 1'b0;
  endtask

  task automatic drain();
    bus.rsp_rdy = 1'b1;
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) tick(1);
    tick(2);
    check("drain_q",   DW'(exp_q.size()), DW'(0));
    check("drain_vld", DW'(bus.rsp_vld),  DW'(0));
  endtask

  // Read one line from an idle controller and check the returned data.
  task automatic read_expect(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    send(mk_req(1'b0, a, '0, '0));
    for (int n = 0; n < 10 && !bus.rsp_vld; n++) tick(1);
    check({tag, "_vld"}, DW'(bus.rsp_vld), DW'(1));
    check(tag, bus.rsp_rdata, exp);
    drain();
  endtask

  task automatic wait_init(input int start);
    int n;
    n = start;
    while (!init_done && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("init_latency", DW'(n), DW'(16385));
  endtask

  // Re-arm the pin/response monitor after reset has been released.
  task automatic bring_up(input int start);
`ifdef CT_SPSRAM_INIT_EN
    wait_init(start);
    ref_mem.delete();
    exp_a = '1;
`else
    exp_a = '0;
    tick(1);
`endif
    exp_d    = '0;
    exp_cen  = 1'b1;
    exp_gwen = 1'b1;
    exp_wen  = '1;
    check("rdy_after_rst", DW'(bus.req_rdy), DW'(1));
    chk_en = 1'b1;
  endtask

  task automatic reset_pins_check(input string tag);
    check({tag, "_rsp_vld"}, DW'(bus.rsp_vld),   DW'(0));
    check({tag, "_rdata"},   bus.rsp_rdata,       '0);
    check({tag, "_cen"},     DW'(sram_cen),       DW'(1));
    check({tag, "_gwen"},    DW'(sram_gwen),      DW'(1));
    check({tag, "_wen"},     sram_wen,            '1);
    check({tag, "_a"},       DW'(sram_a),         DW'(0));
  endtask

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] d;
    int k, c0, r0;
    logic acc;
    bus.req_vld = 1'b0; bus.req_wr = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_wstrb = '0; bus.rsp_rdy = 1'b1;

    repeat (3) @(posedge clk);
    #2;
    reset_pins_check("rst");
    check("rst_d", sram_d, '0);
`ifdef CT_SPSRAM_INIT_EN
    check("rst_init_done", DW'(init_done), DW'(0));
    @(negedge clk) rst_b = 1'b1;
    // Interrupt the sweep at cycle 100; it must restart from address 0.
    repeat (100) @(posedge clk);
    #1;
    check("sweep_busy", DW'(init_done), DW'(0));
    check("sweep_rdy",  DW'(bus.req_rdy), DW'(0));
    check("sweep_a",    DW'(sram_a), DW'(99));
    #2 rst_b = 1'b0;
    #1 reset_pins_check("sweep_rst");
    @(negedge clk) rst_b = 1'b1;
    tick(1);
    check("restart_a",    DW'(sram_a),    DW'(0));
    check("restart_cen",  DW'(sram_cen),  DW'(0));
    check("restart_gwen", DW'(sram_gwen), DW'(0));
    check("restart_wen",  sram_wen,       '0);
    tick(1);
    check("restart_a1",   DW'(sram_a),    DW'(1));
    bring_up(2);
    read_expect("init_0",    14'h0000, '0);
    read_expect("init_2000", 14'h2000, '0);
    read_expect("init_3fff", 14'h3FFF, '0);
`else
    check("rst_init_done", DW'(init_done), DW'(1));
    @(negedge clk) rst_b = 1'b1;
    bring_up(0);
`endif

    // Basic write/read with latency.
    send(mk_req(1'b1, 14'h0010, {SW{8'hA5}}, '1));
    send(mk_req(1'b0, 14'h0010, '0, '0));
    check("lat_t0", DW'(bus.rsp_vld), DW'(0));
    tick(1);
    check("lat_t1", DW'(bus.rsp_vld), DW'(0));
    tick(1);
    check("lat_t2", DW'(bus.rsp_vld), DW'(1));
    check("basic_rd", bus.rsp_rdata, {SW{8'hA5}});
    drain();

    // Byte strobes, then a write with no strobes at all.
    send(mk_req(1'b1, 14'h3FFF, '1, '1));
    send(mk_req(1'b1, 14'h3FFF, '0, SW'(1)));
    read_expect("strb_rd", 14'h3FFF, {{(SW-1){8'hFF}}, 8'h00});
    send(mk_req(1'b1, 14'h3FFF, {4{$urandom}}, '0));
    read_expect("strb0_rd", 14'h3FFF, {{(SW-1){8'hFF}}, 8'h00});

    // Backpressure: 6 reads against 4 credits.
    for (int i = 0; i < 6; i++) send(mk_req(1'b1, AW'(14'h100 + i), {4{$urandom}}, '1));
    bus.rsp_rdy = 1'b0;
    r0 = rsp_cnt;
    k = 0;
    bus.req_wr = 1'b0;
    for (int c = 0; c < 6; c++) begin
      bus.req_vld  = 1'b1;
      bus.req_addr = AW'(14'h100 + k);
      @(negedge clk);
      acc = bus.req_rdy;
      @(posedge clk);
      #1;
      if (acc) k++;
    end
    check("bp_accepted", DW'(k), DW'(4));
    check("bp_rdy_low",  DW'(bus.req_rdy), DW'(0));
    check("bp_rsp_vld",  DW'(bus.rsp_vld), DW'(1));
    bus.rsp_rdy = 1'b1;
    for (int n = 0; n < 50 && k < 6; n++) begin
      bus.req_addr = AW'(14'h100 + k);
      @(negedge clk);
      acc = bus.req_rdy;
      @(posedge clk);
      #1;
      if (acc) k++;
    end
    bus.req_vld = 1'b0;
    check("bp_all_accepted", DW'(k), DW'(6));
    drain();
    check("bp_rsp_count", DW'(rsp_cnt - r0), DW'(6));

    // Back-to-back write/read to address 5.
    c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      send(mk_req(1'b1, 14'h0005, d, '1));
      send(mk_req(1'b0, 14'h0005, '0, '0));
    end
    check("b2b_cycles", DW'(cyc - c0), DW'(16));
    drain();

    // Randomized traffic over a small pre-written address window.
    for (int a = 0; a < 16; a++) send(mk_req(1'b1, AW'(a), {4{$urandom}}, '1));
    rnd_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bus.rsp_rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) tick(1);
      send(mk_req(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
                  {$urandom, $urandom, $urandom, $urandom}, SW'({$urandom, $urandom})));
    end
    rnd_rdy = 1'b0;
    drain();

    // Reset with three reads in flight.
    bus.rsp_rdy = 1'b0;
    for (int i = 0; i < 3; i++) send(mk_req(1'b0, AW'(i), '0, '0));
    tick(1);
    chk_en = 1'b0;
    exp_q.delete();
    #2 rst_b = 1'b0;
    #1 reset_pins_check("mid_rst");
    @(negedge clk) rst_b = 1'b1;
    bus.rsp_rdy = 1'b1;
    r0 = rsp_cnt;
    bring_up(0);
    tick(20);
    check("no_stale_vld", DW'(bus.rsp_vld), DW'(0));
    check("no_stale_cnt", DW'(rsp_cnt - r0), DW'(0));
    read_expect("post_rst_rd", 14'h0010, ref_rd(16));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_ct_spsram_req_ctrl
`default_nettype wire
